// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 operate-instruction constants, states and helpers
//
// Purpose: opcode constants, sequencer state encoding, NZP reset value and a
//          helper that derives the condition codes from a 16-bit result.
// Ports:   none (package).

package lc3_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;

   localparam logic [2:0] NZP_RESET = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Exactly one of {N,Z,P} is set for any 16-bit value.
   function automatic logic [2:0] nzp_of(input logic [15:0] value);
      if (value[15])
         return 3'b100;
      else if (value == 16'h0000)
         return 3'b010;
      else
         return 3'b001;
   endfunction

   function automatic logic is_legal(input logic [3:0] opcode);
      return (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
   endfunction

endpackage

// File: rtl/lc3_alu.sv
// rtl/lc3_alu.sv - combinational ADD/AND/NOT datapath for the operate sequencer
//
// Purpose: computes the operate-instruction result and the condition codes it
//          would produce.
// Ports:   opcode   in  4   INSTR[15:12]
//          a        in  16  source-1 operand
//          b        in  16  source-2 operand (used when imm_sel = 0)
//          imm_sel  in  1   INSTR[5]; selects sign-extended imm5 over b
//          imm5     in  5   INSTR[4:0]
//          result   out 16  ALU result (0 for unsupported opcodes)
//          nzp_next out 3   {N,Z,P} derived from result

module lc3_alu
   import lc3_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        imm_sel,
   input  logic [4:0]  imm5,
   output logic [15:0] result,
   output logic [2:0]  nzp_next
);

   logic [15:0] operand;

   always_comb begin
      operand = imm_sel ? {{11{imm5[4]}}, imm5} : b;
      case (opcode)
         OP_ADD:  result = a + operand;  // wraps modulo 2^16, no overflow flag
         OP_AND:  result = a & operand;
         OP_NOT:  result = ~a;
         default: result = 16'h0000;
      endcase
      nzp_next = nzp_of(result);
   end

endmodule

// File: rtl/lc3_alu_sequencer.sv
// rtl/lc3_alu_sequencer.sv - four-cycle ADD/AND/NOT sequencer driving the LC-3 register file
//
// Purpose: accepts one operate instruction per handshake, reads its operands
//          from the register file, writes back the result and keeps NZP.
// Ports:   CLK, RESET (async, active high)
//          INSTR[15:0], INSTR_VALID in / INSTR_READY out  instruction handshake
//          RS1[2:0], RS2[2:0] out; RS1_DATA, RS2_DATA[15:0] in  register reads
//          RD[2:0], RD_LE, DATA_IN[15:0] out                  register write
//          NZP[2:0], DONE, ILLEGAL out                        status

module lc3_alu_sequencer
   import lc3_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] INSTR,
   input  logic        INSTR_VALID,
   output logic        INSTR_READY,
   output logic [2:0]  RS1,
   output logic [2:0]  RS2,
   input  logic [15:0] RS1_DATA,
   input  logic [15:0] RS2_DATA,
   output logic [2:0]  RD,
   output logic        RD_LE,
   output logic [15:0] DATA_IN,
   output logic [2:0]  NZP,
   output logic        DONE,
   output logic        ILLEGAL
);

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [2:0]  dr_q, dr_d;
   logic        imm_sel_q, imm_sel_d;
   logic [4:0]  imm5_q, imm5_d;
   logic        legal_q, legal_d;
   logic [2:0]  nzp_pend_q, nzp_pend_d;
   logic [2:0]  rs1_q, rs1_d;
   logic [2:0]  rs2_q, rs2_d;
   logic [2:0]  rd_q, rd_d;
   logic        rd_le_q, rd_le_d;
   logic [15:0] data_in_q, data_in_d;
   logic [2:0]  nzp_q, nzp_d;
   logic        done_q, done_d;
   logic        illegal_q, illegal_d;

   logic [15:0] alu_result;
   logic [2:0]  alu_nzp;

   lc3_alu u_alu (
      .opcode   (op_q),
      .a        (RS1_DATA),
      .b        (RS2_DATA),
      .imm_sel  (imm_sel_q),
      .imm5     (imm5_q),
      .result   (alu_result),
      .nzp_next (alu_nzp)
   );

   // Reset is folded in so no instruction can be handshaked while it is held.
   assign INSTR_READY = (state_q == IDLE) && !RESET;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dr_d       = dr_q;
      imm_sel_d  = imm_sel_q;
      imm5_d     = imm5_q;
      legal_d    = legal_q;
      nzp_pend_d = nzp_pend_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      rd_le_d    = 1'b0;
      data_in_d  = data_in_q;
      nzp_d      = nzp_q;
      done_d     = 1'b0;
      illegal_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (INSTR_VALID) begin
               op_d      = INSTR[15:12];
               dr_d      = INSTR[11:9];
               imm_sel_d = INSTR[5];
               imm5_d    = INSTR[4:0];
               rs1_d     = INSTR[8:6];
               rs2_d     = INSTR[2:0];
               state_d   = READ;
            end
         end
         READ: begin
            // Register file samples RS1/RS2 on this closing edge.
            state_d = EXEC;
         end
         EXEC: begin
            legal_d = is_legal(op_q);
            if (is_legal(op_q)) begin
               data_in_d  = alu_result;
               rd_d       = dr_q;
               rd_le_d    = 1'b1;
               nzp_pend_d = alu_nzp;
            end
            state_d = WRITE;
         end
         WRITE: begin
            // NZP commits on the same edge the register file takes the write.
            if (legal_q)
               nzp_d = nzp_pend_q;
            done_d    = 1'b1;
            illegal_d = !legal_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         op_q       <= 4'h0;
         dr_q       <= 3'd0;
         imm_sel_q  <= 1'b0;
         imm5_q     <= 5'd0;
         legal_q    <= 1'b0;
         nzp_pend_q <= NZP_RESET;
         rs1_q      <= 3'd0;
         rs2_q      <= 3'd0;
         rd_q       <= 3'd0;
         rd_le_q    <= 1'b0;
         data_in_q  <= 16'h0000;
         nzp_q      <= NZP_RESET;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dr_q       <= dr_d;
         imm_sel_q  <= imm_sel_d;
         imm5_q     <= imm5_d;
         legal_q    <= legal_d;
         nzp_pend_q <= nzp_pend_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         rd_le_q    <= rd_le_d;
         data_in_q  <= data_in_d;
         nzp_q      <= nzp_d;
         done_q     <= done_d;
         illegal_q  <= illegal_d;
      end
   end

   assign RS1     = rs1_q;
   assign RS2     = rs2_q;
   assign RD      = rd_q;
   assign RD_LE   = rd_le_q;
   assign DATA_IN = data_in_q;
   assign NZP     = nzp_q;
   assign DONE    = done_q;
   assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// tb/tb_lc3_alu_sequencer.sv - vector-table bench for lc3_alu_sequencer with a register file model

module tb_lc3_alu_sequencer;

   typedef struct {
      logic [15:0] instr;
      logic [2:0]  rd;
      logic [15:0] data;
      logic [2:0]  nzp;
      logic        ill;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] INSTR;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [2:0]  RS1, RS2, RD;
   logic [15:0] RS1_DATA, RS2_DATA, DATA_IN;
   logic        RD_LE, DONE, ILLEGAL;
   logic [2:0]  NZP;

   logic        rf_rst;
   logic [15:0] rf [0:7];

   int n_cmp = 0;
   int n_err = 0;

   vec_t tbl [0:20];

   lc3_alu_sequencer dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTR       (INSTR),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .RS1         (RS1),
      .RS2         (RS2),
      .RS1_DATA    (RS1_DATA),
      .RS2_DATA    (RS2_DATA),
      .RD          (RD),
      .RD_LE       (RD_LE),
      .DATA_IN     (DATA_IN),
      .NZP         (NZP),
      .DONE        (DONE),
      .ILLEGAL     (ILLEGAL)
   );

   always #5 CLK = ~CLK;

   // Register file model: registered reads, write on RD_LE, own reset.
   always @(posedge CLK or posedge rf_rst) begin
      if (rf_rst) begin
         for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
         RS1_DATA <= 16'h0000;
         RS2_DATA <= 16'h0000;
      end else begin
         RS1_DATA <= rf[RS1];
         RS2_DATA <= rf[RS2];
         if (RD_LE) rf[RD] <= DATA_IN;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] instr, input logic [2:0] rd,
                               input logic [15:0] data, input logic [2:0] nzp, input logic ill);
      vec_t v;
      v.instr = instr; v.rd = rd; v.data = data; v.nzp = nzp; v.ill = ill;
      return v;
   endfunction

   // Entered and left at a negedge; VALID stays high so successive calls are back-to-back.
   task automatic run_vec(input vec_t v, input bit chk_gap);
      int          wait_n;
      int          le_n;
      logic        early_done;
      logic        early_ready;
      logic [2:0]  rd_c;
      logic [15:0] d_c;
      INSTR       = v.instr;
      INSTR_VALID = 1'b1;
      wait_n = 0;
      while (!INSTR_READY && wait_n < 20) begin
         @(negedge CLK);
         wait_n++;
      end
      if (!INSTR_READY) begin
         check("accept_timeout", 32'd0, 32'd1);
         return;
      end
      if (chk_gap) check("b2b_gap", wait_n, 0);
      @(posedge CLK);
      #1 INSTR = 16'hF000;  // must be ignored outside IDLE
      le_n = 0; early_done = 1'b0; early_ready = 1'b0; rd_c = 3'd0; d_c = 16'h0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         if (RD_LE) begin
            le_n++;
            rd_c = RD;
            d_c  = DATA_IN;
         end
         if (k < 4) begin
            early_done  = early_done | DONE | ILLEGAL;
            early_ready = early_ready | INSTR_READY;
         end
      end
      check("early_done", early_done, 0);
      check("busy_ready", early_ready, 0);
      check("done", DONE, 1);
      check("illegal", ILLEGAL, v.ill);
      check("nzp", NZP, v.nzp);
      check("ready_after", INSTR_READY, 1);
      check("rd_le_cycles", le_n, v.ill ? 0 : 1);
      if (!v.ill) begin
         check("rd", rd_c, v.rd);
         check("data_in", d_c, v.data);
         check("rf_write", rf[v.rd], v.data);
      end
   endtask

   initial begin
      logic any_le;
      logic any_done;

      tbl[0]  = mk(16'h1225, 3'd1, 16'h0005, 3'b001, 1'b0);  // ADD R1,R0,#5
      tbl[1]  = mk(16'h1230, 3'd1, 16'hFFF0, 3'b100, 1'b0);  // ADD R1,R0,#-16
      tbl[2]  = mk(16'h967F, 3'd3, 16'h000F, 3'b001, 1'b0);  // NOT R3,R1
      tbl[3]  = mk(16'h18C3, 3'd4, 16'h001E, 3'b001, 1'b0);  // ADD R4,R3,R3
      tbl[4]  = mk(16'h0000, 3'd0, 16'h0000, 3'b001, 1'b1);  // illegal, NZP held
      tbl[5]  = mk(16'h5A60, 3'd5, 16'h0000, 3'b010, 1'b0);  // AND R5,R1,#0
      tbl[6]  = mk(16'h5443, 3'd2, 16'h0000, 3'b010, 1'b0);  // AND R2,R1,R3
      tbl[7]  = mk(16'h1D04, 3'd6, 16'h003C, 3'b001, 1'b0);  // ADD R6,R4,R4
      tbl[8]  = mk(16'h1D86, 3'd6, 16'h0078, 3'b001, 1'b0);  // ADD R6,R6,R6 ...
      tbl[9]  = mk(16'h1D86, 3'd6, 16'h00F0, 3'b001, 1'b0);
      tbl[10] = mk(16'h1D86, 3'd6, 16'h01E0, 3'b001, 1'b0);
      tbl[11] = mk(16'h1D86, 3'd6, 16'h03C0, 3'b001, 1'b0);
      tbl[12] = mk(16'h1D86, 3'd6, 16'h0780, 3'b001, 1'b0);
      tbl[13] = mk(16'h1D86, 3'd6, 16'h0F00, 3'b001, 1'b0);
      tbl[14] = mk(16'h1D86, 3'd6, 16'h1E00, 3'b001, 1'b0);
      tbl[15] = mk(16'h1D86, 3'd6, 16'h3C00, 3'b001, 1'b0);
      tbl[16] = mk(16'h1D86, 3'd6, 16'h7800, 3'b001, 1'b0);
      tbl[17] = mk(16'h1D86, 3'd6, 16'hF000, 3'b100, 1'b0);  // 0x7800+0x7800
      tbl[18] = mk(16'h1D86, 3'd6, 16'hE000, 3'b100, 1'b0);  // carry out dropped
      tbl[19] = mk(16'hF025, 3'd0, 16'h0000, 3'b100, 1'b1);  // TRAP opcode, illegal
      tbl[20] = mk(16'h5FBF, 3'd7, 16'hE000, 3'b100, 1'b0);  // AND R7,R6,#-1

      RESET = 1'b1; rf_rst = 1'b1; INSTR = 16'h0000; INSTR_VALID = 1'b0;
      @(negedge CLK); @(negedge CLK);
      check("rst_rs1", RS1, 0);
      check("rst_rs2", RS2, 0);
      check("rst_rd", RD, 0);
      check("rst_data_in", DATA_IN, 0);
      check("rst_rd_le", RD_LE, 0);
      check("rst_done", DONE, 0);
      check("rst_illegal", ILLEGAL, 0);
      check("rst_nzp", NZP, 3'b010);
      check("rst_ready", INSTR_READY, 0);
      RESET = 1'b0; rf_rst = 1'b0;
      #1 check("ready_release", INSTR_READY, 1);
      @(negedge CLK);

      for (int i = 0; i < 21; i++) run_vec(tbl[i], i > 0);

      // Reset during EXEC: write discarded, NZP back to 010, R5 untouched.
      INSTR = 16'h1B61;  // ADD R5,R5,#1
      INSTR_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("mid_rst_rd_le", RD_LE, 0);
      check("mid_rst_nzp", NZP, 3'b010);
      check("mid_rst_ready", INSTR_READY, 0);
      check("mid_rst_done", DONE, 0);
      @(negedge CLK); @(negedge CLK);
      check("rst_valid_ready", INSTR_READY, 0);
      INSTR_VALID = 1'b0;
      RESET = 1'b0;
      #1 check("mid_rst_release_ready", INSTR_READY, 1);
      any_le = 1'b0; any_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         any_le   = any_le | RD_LE;
         any_done = any_done | DONE | ILLEGAL;
      end
      check("mid_rst_no_write", any_le, 0);
      check("mid_rst_no_done", any_done, 0);
      check("mid_rst_r5", rf[5], 16'h0000);

      run_vec(mk(16'h1225, 3'd1, 16'h0005, 3'b001, 1'b0), 1'b0);
      INSTR_VALID = 1'b0;
      @(negedge CLK);
      check("done_one_cycle", DONE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/lc3_alu_sequencer.md
# lc3_alu_sequencer

Operate-instruction sequencer that drives the LC-3 register file: it accepts one 16-bit ADD/AND/NOT instruction per handshake, issues source addresses to the register file and captures the registered operands one cycle later. It then computes the result and issues a single-cycle write-back (RD, RD_LE, DATA_IN). It also maintains the N/Z/P condition codes and sits between the fetch/decode front end and the register file's write and read ports.

## Interface
- No parameters; data width is fixed at 16, register address width at 3.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INSTR  in  16  instruction word; sampled only when INSTR_VALID and INSTR_READY are both high.
- INSTR_VALID  in  1  instruction offered.
- INSTR_READY  out  1  high only in IDLE and while RESET is low.
- RS1  out  3  source-1 address to register file.
- RS2  out  3  source-2 address to register file.
- RS1_DATA  in  16  register file source-1 data, valid one clock after RS1 is driven.
- RS2_DATA  in  16  register file source-2 data, same timing.
- RD  out  3  destination address.
- RD_LE  out  1  write enable, exactly one cycle per legal instruction.
- DATA_IN  out  16  write-back data.
- NZP  out  3  condition codes {N,Z,P}.
- DONE  out  1  one-cycle completion pulse.
- ILLEGAL  out  1  one-cycle pulse, coincident with DONE, for unsupported opcodes.

## Operation
- Decoding uses INSTR[15:12]: 0001 = ADD, 0101 = AND, 1001 = NOT; any other opcode is illegal.
- Fields: DR = [11:9] and SR1 = [8:6]. If bit5 = 1, the operand is imm5 = [4:0], sign-extended to 16 bits. If bit5 = 0, SR2 = [2:0].
- NOT ignores [5:0] and computes ~RS1_DATA.
- ADD wraps modulo 2^16 and has no overflow flag. AND is bitwise.
- NZP is set from the 16-bit result: N = bit15; Z = result==0; P otherwise. Exactly one bit is set.
- State machine:
  - IDLE: READY high. On VALID&READY, latch INSTR, load RS1 <= SR1 and RS2 <= SR2, and go to READ.
  - READ: wait one cycle while the register file latches the operands. Go to EXEC.
  - EXEC: RS1_DATA and RS2_DATA are valid. For a legal opcode, register DATA_IN <= result, RD <= DR and RD_LE <= 1. For an illegal opcode, RD_LE stays 0. Go to WRITE.
  - WRITE: RD_LE is high this cycle for a legal opcode. At the closing edge:
    - clear RD_LE;
    - update NZP (legal opcodes only);
    - assert DONE, plus ILLEGAL if the opcode was illegal;
    - go to IDLE.
- DONE and ILLEGAL are high for the first IDLE cycle only.
- The unused RD_DATA read port of the register file is not connected.
- The block is non-pipelined, so there are no data hazards. A following instruction always reads the prior result.

## Timing
- Edge A accepts the instruction. Edge B: register file latches the operands. Edge C: write-back signals are registered. Edge D: register file writes and NZP updates. DONE is high in the cycle after D.
- Earliest next acceptance is the edge after D, giving 4 cycles per instruction.
- INSTR_VALID may stay high continuously. INSTR is ignored outside IDLE.
- Reset values: RS1 = RS2 = RD = 0, DATA_IN = 0, RD_LE = 0, DONE = 0, ILLEGAL = 0, NZP = 3'b010, state = IDLE.
- INSTR_READY is 0 while RESET is high and 1 on the first cycle after release.
- Reset mid-operation: RD_LE drops immediately (asynchronously), so a pending write is discarded and no DONE is issued.
- Simultaneous VALID and RESET: the instruction is not accepted.

## Structure
- Shared package lc3_pkg holds:
  - opcode constants OP_ADD = 4'b0001, OP_AND = 4'b0101, OP_NOT = 4'b1001;
  - state encoding IDLE/READ/EXEC/WRITE;
  - NZP reset constant 3'b010.
- One combinational sub-module, lc3_alu:
  - inputs: opcode, a, b, imm_sel, imm5;
  - outputs: result and nzp_next.
- The sequencer owns all registers and the FSM.

## Test plan
The bench pairs this block with the LC-3 register file model. All registers start at 0 after the register file's reset.
- ADD R1,R0,#5 (0x1225) → RD_LE one cycle with RD = 1, DATA_IN = 0x0005; NZP = 001; DONE pulse 4 cycles after acceptance.
- ADD R1,R0,#-16 (0x1230) → R1 = 0xFFF0, NZP = 100. Then NOT R3,R1 (0x967F) → R3 = 0x000F, NZP = 001.
- Back-to-back with VALID held high: ADD R4,R3,R3 (0x18C3) right after the NOT → accepted exactly 4 cycles later; R4 = 0x001E (uses the new R3).
- AND R5,R1,#0 (0x5A60) → R5 = 0x0000, NZP = 010. ADD R6,R4,R4 repeated until 0x7800+0x7800 → 0xF000, N set (wrap, no flag).
- Illegal 0x0000 → RD_LE never asserted; NZP unchanged; DONE and ILLEGAL high together for one cycle.
- RESET asserted during EXEC → RD_LE and DONE stay 0; NZP = 010 immediately; INSTR_READY = 1 on the first cycle after release; the destination register is unmodified.
